seg_scan_capture: RTL and testbench

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg_pattern_decode.sv | 35 +++
 rtl/seg_scan_capture.sv | 128 ++++++++++++
 tb/tb_seg_scan_capture.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns, codes, FSM encoding and anode helpers
package seg_pkg;

    // Active-low segment patterns, bit6=g .. bit0=a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_ERR  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } seg_state_t;

    // An anode sample is usable only when exactly one digit is driven
    function automatic logic an_valid(input logic [3:0] an_n);
        logic v;
        case (an_n)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: v = 1'b1;
            default:                            v = 1'b0;
        endcase
        return v;
    endfunction

    // Digit index of the single low anode bit (0 when not one-hot)
    function automatic logic [1:0] an_index(input logic [3:0] an_n);
        logic [1:0] idx;
        case (an_n)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational 7-segment pattern to BCD decoder
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       blank,
    output logic       err
);

    // Map a pattern to its digit; blank yields code 0, anything unknown yields the error code
    always_comb begin
        code  = 4'h0;
        blank = 1'b0;
        err   = 1'b0;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default: begin
                code = CODE_ERR;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - captures a multiplexed 4-digit 7-segment scan into BCD frames
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_done,
    output logic        pattern_err,
    output logic [1:0]  err_digit
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    seg_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] prev_an;
    logic [6:0] prev_seg;
    logic       accept;
    logic       sample_valid;
    logic       changed;

    logic [3:0]  dec_code;
    logic        dec_blank;
    logic        dec_err;
    logic [1:0]  idx;

    logic [15:0] stage_digits, stage_digits_nxt;
    logic [3:0]  stage_blank, stage_blank_nxt;
    logic [3:0]  seen, seen_nxt;

    seg_pattern_decode u_decode (
        .pattern (seg_n),
        .code    (dec_code),
        .blank   (dec_blank),
        .err     (dec_err)
    );

    assign sample_valid = en && an_valid(an_n);
    assign changed      = (an_n != prev_an) || (seg_n != prev_seg);
    assign idx          = an_index(an_n);

    // State register, stability counter and previous-sample history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            prev_an  <= 4'hF;
            prev_seg <= SEG_BLANK;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prev_an  <= an_n;
            prev_seg <= seg_n;
        end
    end

    // Next state: restart on any change, count identical samples, accept once per HELD stay
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        if (!sample_valid) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 8'd0;
        end else if (state == ST_IDLE || changed) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = 8'd1;
        end else begin
            if (cnt < STABLE_MAX) begin
                cnt_nxt = cnt + 8'd1;
            end
            if (state == ST_SETTLE && cnt_nxt == STABLE_MAX) begin
                accept    = 1'b1;
                state_nxt = ST_HELD;
            end
        end
    end

    // Staging view including the sample accepted this cycle, so a frame can close on it
    always_comb begin
        stage_digits_nxt = stage_digits;
        stage_blank_nxt  = stage_blank;
        seen_nxt         = seen;
        if (accept) begin
            stage_digits_nxt[{idx, 2'b00} +: 4] = dec_code;
            stage_blank_nxt[idx]                = dec_blank;
            seen_nxt[idx]                       = 1'b1;
        end
    end

    // Staging slots, frame publication and sticky error tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_digits <= 16'h0000;
            stage_blank  <= 4'h0;
            seen         <= 4'h0;
            digits       <= 16'h0000;
            blank        <= 4'hF;
            frame_done   <= 1'b0;
            pattern_err  <= 1'b0;
            err_digit    <= 2'd0;
        end else begin
            frame_done   <= 1'b0;
            stage_digits <= stage_digits_nxt;
            stage_blank  <= stage_blank_nxt;
            if (accept && dec_err) begin
                pattern_err <= 1'b1;
                err_digit   <= idx;
            end
            if (seen_nxt == 4'hF) begin
                digits     <= stage_digits_nxt;
                blank      <= stage_blank_nxt;
                seen       <= 4'h0;
                frame_done <= 1'b1;
            end else begin
                seen <= seen_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - randomized and directed self-checking bench for seg_scan_capture
module tb_seg_scan_capture;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        frame_done;
    logic        pattern_err;
    logic [1:0]  err_digit;

    always #5 clk = ~clk;

    seg_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .digits      (digits),
        .blank       (blank),
        .frame_done  (frame_done),
        .pattern_err (pattern_err),
        .err_digit   (err_digit)
    );

    int checks = 0;
    int failures = 0;
    int fd_count = 0;

    // Reference model state
    logic [6:0]  pats [0:9];
    int          run;
    logic [3:0]  pan;
    logic [6:0]  pseg;
    logic [3:0]  st_code [0:3];
    logic        st_blank [0:3];
    logic        m_seen [0:3];
    logic [15:0] m_digits;
    logic [3:0]  m_blank;
    logic        m_fd;
    logic        m_perr;
    logic [1:0]  m_edig;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_low(input logic [3:0] a);
        int c = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) c++;
        return c;
    endfunction

    function automatic logic [3:0] an_of(input int k);
        logic [3:0] one = 4'b0001;
        return ~(one << k);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [3:0] a, input logic [6:0] s);
        m_fd = 1'b0;
        if (!r) begin
            run = 0;
            for (int i = 0; i < 4; i++) begin
                st_code[i] = 4'h0; st_blank[i] = 1'b0; m_seen[i] = 1'b0;
            end
            m_digits = 16'h0000; m_blank = 4'hF; m_perr = 1'b0; m_edig = 2'd0;
        end else begin
            logic valid;
            valid = e && (count_low(a) == 1);
            if (!valid) run = 0;
            else if (run > 0 && a == pan && s == pseg) run++;
            else run = 1;
            if (valid && run == STABLE) begin
                int k;
                logic [3:0] code;
                logic bl;
                logic found;
                k = 0;
                for (int i = 0; i < 4; i++) if (!a[i]) k = i;
                found = 1'b0; code = 4'hF; bl = 1'b0;
                for (int i = 0; i < 10; i++) if (s == pats[i]) begin code = 4'(i); found = 1'b1; end
                if (!found && s == 7'h7F) begin code = 4'h0; bl = 1'b1; found = 1'b1; end
                if (!found) begin m_perr = 1'b1; m_edig = 2'(k); end
                st_code[k] = code; st_blank[k] = bl; m_seen[k] = 1'b1;
                if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
                    m_digits = {st_code[3], st_code[2], st_code[1], st_code[0]};
                    m_blank  = {st_blank[3], st_blank[2], st_blank[1], st_blank[0]};
                    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
                    m_fd = 1'b1;
                end
            end
        end
        pan = a;
        pseg = s;
    endtask

    task automatic compare();
        chk("digits", digits, m_digits);
        chk("blank", blank, m_blank);
        chk("frame_done", frame_done, m_fd);
        chk("pattern_err", pattern_err, m_perr);
        chk("err_digit", err_digit, m_edig);
        if (frame_done === 1'b1) fd_count++;
    endtask

    task automatic cycle(input logic r, input logic e, input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        compare();
        rst_n = r; en = e; an_n = a; seg_n = s;
        model_step(r, e, a, s);
    endtask

    task automatic hold(input int k, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, an_of(k), s);
    endtask

    task automatic idle1();
        cycle(1'b1, 1'b0, 4'hF, 7'h7F);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 4'hF, 7'h7F);
        cycle(1'b0, 1'b0, 4'hF, 7'h7F);
        idle1();
    endtask

    int fd0;

    initial begin
        pats[0] = 7'h40; pats[1] = 7'h79; pats[2] = 7'h24; pats[3] = 7'h30; pats[4] = 7'h19;
        pats[5] = 7'h12; pats[6] = 7'h02; pats[7] = 7'h78; pats[8] = 7'h00; pats[9] = 7'h18;
        model_step(1'b0, 1'b0, 4'hF, 7'h7F);

        // Reset state
        do_reset();
        idle1();
        chk("reset_digits", digits, 16'h0000);
        chk("reset_blank", blank, 4'hF);
        chk("reset_perr", pattern_err, 1'b0);

        // Plain scan 1,2,3,4
        fd0 = fd_count;
        hold(0, 7'h79, 8); hold(1, 7'h24, 8); hold(2, 7'h30, 8); hold(3, 7'h19, 8);
        idle1();
        chk("scan_digits", digits, 16'h4321);
        chk("scan_model_digits", m_digits, 16'h4321);
        chk("scan_blank", blank, 4'h0);
        chk("scan_frames", fd_count - fd0, 1);

        // Short hold on the last digit does not complete the frame
        fd0 = fd_count;
        hold(0, 7'h40, 8); hold(1, 7'h79, 8); hold(2, 7'h24, 8); hold(3, 7'h30, STABLE - 1);
        idle1(); idle1();
        chk("short_frames", fd_count - fd0, 0);
        chk("short_digits", digits, 16'h4321);
        hold(3, 7'h30, 8);
        idle1();
        chk("short_done_frames", fd_count - fd0, 1);
        chk("short_done_digits", digits, 16'h3210);

        // Blank on digit 3
        do_reset();
        fd0 = fd_count;
        hold(0, 7'h79, 8); hold(1, 7'h24, 8); hold(2, 7'h30, 8); hold(3, 7'h7F, 8);
        idle1();
        chk("blank_mask", blank, 4'b1000);
        chk("blank_digits", digits, 16'h0321);
        chk("blank_frames", fd_count - fd0, 1);

        // Error pattern on digit 2, then a clean frame
        do_reset();
        hold(0, 7'h79, 8); hold(1, 7'h24, 8); hold(2, 7'h55, 8); hold(3, 7'h19, 8);
        idle1();
        chk("err_flag", pattern_err, 1'b1);
        chk("err_index", err_digit, 2'd2);
        chk("err_digits", digits, 16'h4F21);
        chk("err_model_digits", m_digits, 16'h4F21);
        hold(0, 7'h79, 8); hold(1, 7'h24, 8); hold(2, 7'h30, 8); hold(3, 7'h19, 8);
        idle1();
        chk("err_sticky", pattern_err, 1'b1);
        chk("err_index_kept", err_digit, 2'd2);
        chk("err_clean_digits", digits, 16'h4321);

        // Invalid anodes interrupt settling
        do_reset();
        fd0 = fd_count;
        hold(1, 7'h24, 8); hold(2, 7'h30, 8); hold(3, 7'h19, 8);
        hold(0, 7'h79, 2);
        cycle(1'b1, 1'b1, 4'b1100, 7'h79);
        hold(0, 7'h79, STABLE - 1);
        cycle(1'b1, 1'b1, 4'b1111, 7'h79);
        hold(0, 7'h79, STABLE - 1);
        idle1(); idle1();
        chk("invalid_frames", fd_count - fd0, 0);
        hold(0, 7'h79, STABLE);
        idle1();
        chk("invalid_done_frames", fd_count - fd0, 1);

        // Reset mid-frame discards captured digits
        do_reset();
        hold(0, 7'h79, 8); hold(1, 7'h24, 8); hold(2, 7'h30, 8); hold(3, 7'h19, 8);
        hold(0, 7'h18, 8); hold(1, 7'h18, 8); hold(2, 7'h18, 8);
        cycle(1'b0, 1'b1, an_of(2), 7'h18);
        fd0 = fd_count;
        idle1();
        chk("midreset_digits", digits, 16'h0000);
        chk("midreset_blank", blank, 4'hF);
        hold(0, 7'h02, 8); hold(1, 7'h02, 8); hold(2, 7'h02, 8);
        idle1();
        chk("midreset_partial_frames", fd_count - fd0, 0);
        chk("midreset_partial_digits", digits, 16'h0000);
        hold(3, 7'h78, 8);
        idle1();
        chk("midreset_frames", fd_count - fd0, 1);
        chk("midreset_new_digits", digits, 16'h7666);

        // Randomized scanning
        for (int seg = 0; seg < 700; seg++) begin
            int kind;
            int k;
            int n;
            logic [6:0] s;
            kind = $urandom_range(0, 99);
            k = $urandom_range(0, 3);
            n = $urandom_range(1, 9);
            if (kind < 70) s = pats[$urandom_range(0, 9)];
            else if (kind < 80) s = 7'h7F;
            else if (kind < 85) s = 7'($urandom);
            else s = 7'h7F;
            if (kind < 85) begin
                hold(k, s, n);
            end else if (kind < 91) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) cycle(1'b1, 1'b1, 4'($urandom), pats[k]);
            end else if (kind < 98) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) cycle(1'b1, 1'b0, an_of(k), pats[k]);
            end else begin
                cycle(1'b0, 1'($urandom), an_of(k), pats[k]);
            end
        end
        idle1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
